// File: rtl/output_scheduler_pkg.sv
// Shared definitions for the packet FIFO word layout and the output scheduler FSM.
// Used by the input stage, the packet FIFO and the output scheduler.
package output_scheduler_pkg;

    localparam int unsigned FIFO_W    = 140;
    localparam int unsigned DATA_MSB  = 139;
    localparam int unsigned DATA_LSB  = 12;
    localparam int unsigned DATA_W    = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned CHSEL_LSB = 4;
    localparam int unsigned CHSEL_W   = 8;
    localparam int unsigned LEN_LSB   = 0;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned MAX_LEN   = DATA_W / WORD_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_SEND,
        ST_DROP
    } state_t;

    // True when exactly one bit of the channel select is set.
    function automatic logic is_onehot(input logic [CHSEL_W-1:0] v);
        return (v != '0) && ((v & (v - CHSEL_W'(1))) == '0);
    endfunction

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_LEN));
    endfunction

endpackage

// File: rtl/output_scheduler_if.sv
// FIFO-side and channel-side signals of the output scheduler.
// master: the scheduler; slave: the FIFO and channel sinks around it.
interface output_scheduler_if #(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned WORD_W = 16
);
    import output_scheduler_pkg::*;

    logic                  fifo_empty;
    logic [FIFO_W-1:0]     data_from_fifo;
    logic                  fifo_r_enable;
    logic [N_CH-1:0]       ch_ready;
    logic [N_CH-1:0]       ch_valid;
    logic [WORD_W-1:0]     data_out;
    logic                  data_last;
    logic                  pkt_drop;
    logic                  busy;

    modport master (
        input  fifo_empty,
        input  data_from_fifo,
        input  ch_ready,
        output fifo_r_enable,
        output ch_valid,
        output data_out,
        output data_last,
        output pkt_drop,
        output busy
    );

    modport slave (
        output fifo_empty,
        output data_from_fifo,
        output ch_ready,
        input  fifo_r_enable,
        input  ch_valid,
        input  data_out,
        input  data_last,
        input  pkt_drop,
        input  busy
    );

endinterface

// File: rtl/output_scheduler.sv
// Pops one packet at a time from the packet FIFO and streams it as 16-bit words
// to the one-hot selected channel; malformed entries are dropped with a pulse.
module output_scheduler
    import output_scheduler_pkg::*;
#(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned WORD_W = 16
) (
    input  logic                clk_in,
    input  logic                rst_n,
    output_scheduler_if.master  bus
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_CH-1:0]     ch_sel_q, ch_sel_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    k_q, k_d;

    logic [DATA_W-1:0]   fifo_data;
    logic [CHSEL_W-1:0]  fifo_ch_sel;
    logic [LEN_W-1:0]    fifo_len;
    logic                entry_ok;

    logic [WORD_BITS-1:0] cur_word;
    logic                 last_word;
    logic                 xfer;

    logic                fifo_r_enable;
    logic [N_CH-1:0]     ch_valid;
    logic [WORD_W-1:0]   data_out;
    logic                data_last;
    logic                pkt_drop;
    logic                busy;

    assign fifo_data   = bus.data_from_fifo[DATA_MSB:DATA_LSB];
    assign fifo_ch_sel = bus.data_from_fifo[CHSEL_LSB +: CHSEL_W];
    assign fifo_len    = bus.data_from_fifo[LEN_LSB +: LEN_W];
    assign entry_ok    = is_onehot(fifo_ch_sel) && len_ok(fifo_len);

    assign last_word = (k_q == len_q - LEN_W'(1));
    assign xfer      = |(ch_sel_q & bus.ch_ready);

    // Word k is taken from the top of the holding register downwards.
    always_comb begin
        cur_word = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (k_q[2:0] == 3'(i)) begin
                cur_word = data_q[DATA_W-1-WORD_BITS*i -: WORD_BITS];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            ch_sel_q <= '0;
            len_q    <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ch_sel_q <= ch_sel_d;
            len_q    <= len_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        ch_sel_d      = ch_sel_q;
        len_d         = len_q;
        k_d           = k_q;
        fifo_r_enable = 1'b0;
        ch_valid      = '0;
        data_out      = '0;
        data_last     = 1'b0;
        pkt_drop      = 1'b0;
        busy          = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so the strobe is low for the whole reset, not just after the edge.
                if (!bus.fifo_empty) begin
                    fifo_r_enable = rst_n;
                    state_d       = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d   = fifo_data;
                ch_sel_d = N_CH'(fifo_ch_sel);
                len_d    = fifo_len;
                k_d      = '0;
                state_d  = entry_ok ? ST_SEND : ST_DROP;
            end
            ST_SEND: begin
                ch_valid  = ch_sel_q;
                data_out  = WORD_W'(cur_word);
                data_last = last_word;
                if (xfer) begin
                    if (last_word) begin
                        k_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
            end
            ST_DROP: begin
                pkt_drop = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.fifo_r_enable = fifo_r_enable;
    assign bus.ch_valid      = ch_valid;
    assign bus.data_out      = data_out;
    assign bus.data_last     = data_last;
    assign bus.pkt_drop      = pkt_drop;
    assign bus.busy          = busy;

endmodule

// File: tb/tb_output_scheduler.sv
// Scoreboard bench for output_scheduler: a FIFO model feeds entries, a reference
// model queues the expected word/drop stream, and a monitor compares DUT output.
module tb_output_scheduler;
    import output_scheduler_pkg::*;

    typedef struct {
        bit          is_drop;
        logic [7:0]  ch;
        logic [15:0] word;
        bit          last;
        int          id;
    } ev_t;

    logic clk_in = 1'b0;
    logic rst_n;

    output_scheduler_if #(.N_CH(8), .WORD_W(16)) bus ();

    output_scheduler #(.N_CH(8), .WORD_W(16)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int pops = 0, xfers = 0, lasts = 0, drops = 0, stalls = 0, cycle = 0;
    int n_staged = 0;
    int pop_cycles[$];

    ev_t exp_q[$];
    logic [FIFO_W-1:0] stage_q[$];
    logic [FIFO_W-1:0] fifo_q[$];

    int         ready_mode = 0;
    logic [7:0] bp_val = 8'hFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: every well-formed entry yields len words top-down, else one drop.
    task automatic push_entry(input logic [7:0] ch, input logic [3:0] len, input logic [127:0] data);
        ev_t e;
        n_staged++;
        stage_q.push_back({data, ch, len});
        if ($countones(ch) == 1 && len >= 1 && len <= 8) begin
            for (int k = 0; k < int'(len); k++) begin
                e.is_drop = 0;
                e.ch      = ch;
                e.word    = data[127-16*k -: 16];
                e.last    = (k == int'(len) - 1);
                e.id      = n_staged;
                exp_q.push_back(e);
            end
        end else begin
            e.is_drop = 1;
            e.ch      = 8'h00;
            e.word    = 16'h0000;
            e.last    = 0;
            e.id      = n_staged;
            exp_q.push_back(e);
        end
    endtask

    task automatic drop_expect_id(input int id);
        ev_t keep[$];
        foreach (exp_q[i]) if (exp_q[i].id != id) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && fifo_q.size() == 0 && stage_q.size() == 0 && !bus.busy)
               && n < 5000) begin
            @(posedge clk_in);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL %s_drain timeout pending=%0d required=0", name, exp_q.size());
        end
        repeat (2) @(posedge clk_in);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // FIFO model: a pop seen during a cycle presents its entry just after the edge.
    initial begin
        logic pend;
        bus.fifo_empty     = 1'b1;
        bus.data_from_fifo = '0;
        forever begin
            @(negedge clk_in);
            pend = bus.fifo_r_enable;
            @(posedge clk_in);
            #1;
            if (pend && fifo_q.size() > 0) bus.data_from_fifo = fifo_q.pop_front();
            while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        logic [31:0] r;
        bus.ch_ready = '1;
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                1: begin
                    r = $urandom;
                    bus.ch_ready = r[7:0] | r[15:8];
                end
                2: bus.ch_ready = bp_val;
                default: bus.ch_ready = '1;
            endcase
        end
    end

    // Monitor
    initial begin
        ev_t  e;
        bit   held_v = 0;
        logic [7:0]  h_valid;
        logic [15:0] h_data;
        logic        h_last;
        forever begin
            @(negedge clk_in);
            cycle++;
            if (!rst_n) begin
                held_v = 0;
            end else begin
                if (bus.fifo_r_enable) begin
                    pops++;
                    pop_cycles.push_back(cycle);
                end
                chk("valid_onehot", 64'($countones(bus.ch_valid) <= 1), 64'd1);
                if (held_v) begin
                    chk("hold_valid", 64'(bus.ch_valid), 64'(h_valid));
                    chk("hold_data", 64'(bus.data_out), 64'(h_data));
                    chk("hold_last", 64'(bus.data_last), 64'(h_last));
                end
                held_v = 0;
                if (bus.pkt_drop) begin
                    drops++;
                    chk("drop_no_valid", 64'(bus.ch_valid), 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_drop actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("drop_kind", 64'(e.is_drop), 64'd1);
                    end
                end else if (|(bus.ch_valid & bus.ch_ready)) begin
                    xfers++;
                    if (bus.data_last) lasts++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_xfer actual=%0h required=none", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_kind", 64'(e.is_drop), 64'd0);
                        chk("xfer_ch", 64'(bus.ch_valid), 64'(e.ch));
                        chk("xfer_word", 64'(bus.data_out), 64'(e.word));
                        chk("xfer_last", 64'(bus.data_last), 64'(e.last));
                    end
                end else if (bus.ch_valid != '0) begin
                    stalls++;
                    held_v  = 1;
                    h_valid = bus.ch_valid;
                    h_data  = bus.data_out;
                    h_last  = bus.data_last;
                end
            end
        end
    end

    initial begin
        int x0, l0, s0, p0, d0, pc0, n;
        logic [127:0] d;
        logic [31:0]  r;
        logic [7:0]   ch;
        logic [3:0]   len;

        // Reset with a pending entry: nothing may come out while rst_n is low.
        rst_n = 1'b0;
        d = rand128();
        d[127:96] = 32'hA5A51234;
        push_entry(8'h04, 4'd2, d);
        repeat (3) @(posedge clk_in);
        #2;
        chk("rst_fifo_empty_seen", 64'(bus.fifo_empty), 64'd0);
        chk("rst_outputs", 64'({bus.fifo_r_enable, bus.busy, bus.pkt_drop, bus.data_last,
                                bus.ch_valid, bus.data_out}), 64'd0);
        @(posedge clk_in);
        #2 rst_n = 1'b1;
        x0 = xfers; l0 = lasts;
        drain("single");
        chk("single_xfers", 64'(xfers - x0), 64'd2);
        chk("single_lasts", 64'(lasts - l0), 64'd1);

        // Empty FIFO
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            #2;
            chk("empty_idle", 64'({bus.fifo_r_enable, bus.busy, bus.pkt_drop, bus.data_last,
                                   bus.ch_valid, bus.data_out}), 64'd0);
        end

        // Backpressure: channel 0 stalls for 4 cycles after the first word.
        x0 = xfers; s0 = stalls;
        @(posedge clk_in);
        push_entry(8'h01, 4'd3, rand128());
        n = 0;
        do begin @(posedge clk_in); n++; end while (xfers < x0 + 1 && n < 200);
        chk("bp_first_word_seen", 64'(xfers >= x0 + 1), 64'd1);
        bp_val = 8'hFE;
        ready_mode = 2;
        repeat (4) @(posedge clk_in);
        ready_mode = 0;
        drain("bp");
        chk("bp_stalls", 64'(stalls - s0), 64'd4);
        chk("bp_xfers", 64'(xfers - x0), 64'd3);

        // Malformed entries
        x0 = xfers; d0 = drops; p0 = pops;
        @(posedge clk_in);
        push_entry(8'h00, 4'd2, rand128());
        push_entry(8'h03, 4'd2, rand128());
        drain("malformed");
        chk("malformed_drops", 64'(drops - d0), 64'd2);
        chk("malformed_pops", 64'(pops - p0), 64'd2);
        chk("malformed_xfers", 64'(xfers - x0), 64'd0);

        // Back-to-back: three queued entries
        x0 = xfers; l0 = lasts; p0 = pops; pc0 = pop_cycles.size();
        @(posedge clk_in);
        push_entry(8'h01, 4'd8, rand128());
        push_entry(8'h80, 4'd1, rand128());
        push_entry(8'h08, 4'd4, rand128());
        drain("b2b");
        chk("b2b_xfers", 64'(xfers - x0), 64'd13);
        chk("b2b_pops", 64'(pops - p0), 64'd3);
        chk("b2b_lasts", 64'(lasts - l0), 64'd3);
        if (pop_cycles.size() >= pc0 + 3) begin
            chk("b2b_gap_len8", 64'(pop_cycles[pc0+1] - pop_cycles[pc0]), 64'd11);
            chk("b2b_gap_len1", 64'(pop_cycles[pc0+2] - pop_cycles[pc0+1]), 64'd4);
        end else begin
            checks++; errors++;
            $display("FAIL b2b_pop_record actual=%0d required=%0d", pop_cycles.size() - pc0, 3);
        end

        // Reset mid-SEND during word index 1 of a len=5 packet.
        x0 = xfers;
        @(posedge clk_in);
        push_entry(8'h10, 4'd5, rand128());
        push_entry(8'h02, 4'd3, rand128());
        n = 0;
        do begin @(posedge clk_in); n++; end while (xfers < x0 + 1 && n < 200);
        #2;
        chk("rst_pre_valid", 64'(bus.ch_valid), 64'h10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({bus.fifo_r_enable, bus.busy, bus.pkt_drop, bus.data_last,
                                    bus.ch_valid, bus.data_out}), 64'd0);
        drop_expect_id(n_staged - 1);
        repeat (2) @(posedge clk_in);
        #2 rst_n = 1'b1;
        drain("rst_mid");
        chk("rst_mid_xfers", 64'(xfers - x0), 64'd4);

        // Randomized traffic with random ready
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            ch  = (r[1:0] != 2'b00) ? (8'h01 << r[4:2]) : r[15:8];
            len = (r[19:16] < 4'd13) ? 4'(1 + (r[23:20] % 8)) : r[27:24];
            push_entry(ch, len, rand128());
            repeat ($urandom_range(0, 12)) @(posedge clk_in);
        end
        drain("random");
        ready_mode = 0;

        chk("total_pops", 64'(pops), 64'(n_staged));
        chk("exp_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/output_scheduler.md
OUTPUT_SCHEDULER -- requirements
Module: output_scheduler

Interface
REQ-001 The module SHALL have parameter N_CH, default 8, the number of output channels (the ch_sel field width).
REQ-002 The module SHALL have parameter WORD_W, default 16, the output word width.
REQ-003 The module SHALL have port clk_in, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The module SHALL have port fifo_empty, input, 1, high when the packet FIFO holds no entry.
REQ-006 The module SHALL have port data_from_fifo, input, 140, the FIFO read word; bits [139:12] are data (oldest word at [139:124]), [11:4] are ch_sel (one-hot), and [3:0] are len (16-bit word count).
REQ-007 The module SHALL have port fifo_r_enable, output, 1, a one-cycle FIFO pop strobe; data is valid the cycle after.
REQ-008 The module SHALL have port ch_ready, input, N_CH, per-channel sink ready.
REQ-009 The module SHALL have port ch_valid, output, N_CH, one-hot valid toward the selected channel.
REQ-010 The module SHALL have port data_out, output, WORD_W, the word shared by all channels.
REQ-011 The module SHALL have port data_last, output, 1, high with the final word of a packet.
REQ-012 The module SHALL have port pkt_drop, output, 1, a one-cycle pulse when a malformed entry is discarded.
REQ-013 The module SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, POP, LOAD, SEND and DROP.
REQ-015 In IDLE with fifo_empty low, the FSM SHALL assert fifo_r_enable for exactly one cycle and go to POP; otherwise it SHALL stay in IDLE with fifo_r_enable low.
REQ-016 POP SHALL wait one cycle for FIFO read latency and then go to LOAD.
REQ-017 LOAD SHALL capture data, ch_sel and len into internal registers.
REQ-018 LOAD SHALL go to SEND when ch_sel has exactly one bit set and 1 <= len <= 8; otherwise it SHALL go to DROP.
REQ-019 DROP SHALL pulse pkt_drop for one cycle, drive no valid, and return to IDLE.
REQ-020 In SEND, data_out SHALL equal word k = data[139-16k -: 16], with k starting at 0, and ch_valid SHALL equal the registered ch_sel.
REQ-021 A word SHALL transfer only in a cycle where ch_valid and ch_ready of the selected channel are both high; k SHALL then increment.
REQ-022 While the selected channel's ready is low, data_out, ch_valid and data_last SHALL hold stable; ready on unselected channels SHALL be ignored.
REQ-023 data_last SHALL be high when k == len-1.
REQ-024 On the last transfer, the FSM SHALL go to IDLE, and ch_valid SHALL be 0 the following cycle.
REQ-025 A new pop SHALL never be issued before the current packet completes or drops; minimum spacing between pops is len+3 cycles.
REQ-026 len=8 SHALL send all 128 data bits; len=1 SHALL send only [139:124].
REQ-027 The word counter SHALL be 4 bits and SHALL never wrap within a packet.
REQ-028 The block SHALL not modify ch_sel or len; channel priority is FIFO order only, with no reordering.

Reset
REQ-029 While rst_n is low (asynchronous), state SHALL be IDLE and fifo_r_enable, ch_valid, data_out, data_last, pkt_drop and busy SHALL all be 0.
REQ-030 Reset asserted mid-SEND SHALL abandon the packet without completing it; after release the block SHALL restart in IDLE and pop the next entry.

Structure
REQ-031 The state enum, the 140-bit field offsets (DATA_MSB=139, CHSEL_LSB=4, LEN_LSB=0) and FIFO_W=140 SHALL live in the shared package used by input_stage and the FIFO.
REQ-032 A one-hot check function (exactly one bit set) SHALL live in the same package.
REQ-033 The block SHALL be a single module with no sub-module; the FSM, the word counter and the 140-bit holding register are all inline.

Verification
REQ-034 Single packet: ch_sel=8'h04, len=2, data[139:108]=32'hA5A51234, ch_ready all 1 -> ch_valid=8'h04 for 2 cycles, data_out=A5A5 then 1234, data_last on the 2nd word.
REQ-035 Backpressure: ch_sel=8'h01, len=3, with ch_ready[0] low for 4 cycles after the 1st word -> the 2nd word is held stable for those 4 cycles, with no loss or duplication.
REQ-036 Malformed entries: ch_sel=8'h00 and then ch_sel=8'h03 -> pkt_drop pulses twice, ch_valid stays 0, and both entries are popped.
REQ-037 Back-to-back: 3 queued entries (len 8, 1, 4) on channels 0, 7 and 3 -> 13 transfers in FIFO order, exactly 3 pops, and data_last asserted 3 times.
REQ-038 Reset mid-SEND: rst_n low during word 2 of len=5 -> outputs go to 0 immediately, and after release the next FIFO entry is sent intact.
REQ-039 Empty FIFO: fifo_empty held 1 -> fifo_r_enable is never asserted, busy=0, and all outputs stay 0.
